// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: codec read handshake, channel sum/trim and FWFT sample FIFO drained by the DFT
// Ports: clk/rst_n (async active-low); codecReadReady/codecLeft/codecRight in, codecRead ack out;
//        sampleReady/inputSample FIFO head out; dftRead consume level in (one pop per rising edge);
//        fifoLevel occupancy out; dropCount saturating overflow count out.
// Optional: define AUDIO_SEQ_PEAK_EN to add peakLevel[9:0], a decaying peak-magnitude meter.
module audio_sample_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int CAPTURE_SHIFT = 8,
  parameter int DROP_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          codecReadReady,
  input  logic signed [23:0]            codecLeft,
  input  logic signed [23:0]            codecRight,
  output logic                          codecRead,
  output logic                          sampleReady,
  output logic signed [15:0]            inputSample,
  input  logic                          dftRead,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic [DROP_W-1:0]             dropCount
`ifdef AUDIO_SEQ_PEAK_EN
  ,
  output logic [9:0]                    peakLevel
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACK, HOLDOFF} state_t;
  state_t state, next_state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic signed [15:0] mem [FIFO_DEPTH];
  logic signed [24:0] sum, trimmed;
  logic signed [15:0] sample;
  logic dft_q, full, push, pop;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;

  always_comb begin
    next_state = state == IDLE ? (codecReadReady ? ACK : IDLE) :
                 state == ACK  ? HOLDOFF :
                 (codecReadReady ? HOLDOFF : IDLE);
  end

  always_comb begin
    codecRead = state == ACK;
  end

  always_comb begin
    sum     = {codecLeft[23], codecLeft} + {codecRight[23], codecRight};
    trimmed = sum >>> CAPTURE_SHIFT;
    sample  = trimmed > 25'sd32767  ? 16'sh7FFF :
              trimmed < -25'sd32768 ? 16'sh8000 : trimmed[15:0];
  end

  // fullness is judged at cycle start, so a same-cycle pop never frees room for the push
  assign full        = fifoLevel == (AW+1)'(FIFO_DEPTH);
  assign push        = codecRead & ~full;
  assign pop         = dftRead & ~dft_q & (fifoLevel != '0);
  assign sampleReady = fifoLevel != '0;
  assign inputSample = sampleReady ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= sample;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoLevel <= '0;
      dropCount <= '0;
      dft_q     <= 1'b0;
    end else begin
      dft_q     <= dftRead;
      wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifoLevel <= push & ~pop ? fifoLevel + (AW+1)'(1) :
                   pop & ~push ? fifoLevel - (AW+1)'(1) : fifoLevel;
      dropCount <= codecRead & full & ~&dropCount ? dropCount + DROP_W'(1) : dropCount;
    end

`ifdef AUDIO_SEQ_PEAK_EN
  logic [15:0] decay_cnt, mag;

  always_comb begin
    mag = sample == 16'sh8000 ? 16'h7FFF : sample[15] ? 16'(-sample) : 16'(sample);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      decay_cnt <= '0;
      peakLevel <= '0;
    end else begin
      decay_cnt <= decay_cnt + 16'd1;
      if (push) peakLevel <= mag[15:6] > peakLevel ? mag[15:6] : peakLevel;
      else if (&decay_cnt && peakLevel != '0) peakLevel <= peakLevel - 10'd1;
    end
`endif
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb_audio_sample_sequencer: directed and randomized checks of the sequencer against a queue-based model
module tb_audio_sample_sequencer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n, codecReadReady, dftRead;
  logic [23:0] codecLeft, codecRight;
  logic codecRead, sampleReady;
  logic signed [15:0] inputSample;
  logic [2:0] fifoLevel;
  logic [7:0] dropCount;
`ifdef AUDIO_SEQ_PEAK_EN
  logic [9:0] peak_level;
`endif
  int checks = 0;
  int failures = 0;
  int q[$];
  int drops = 0;

  audio_sample_sequencer #(.FIFO_DEPTH(DEPTH), .CAPTURE_SHIFT(8), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .codecReadReady(codecReadReady),
    .codecLeft(codecLeft), .codecRight(codecRight), .codecRead(codecRead),
    .sampleReady(sampleReady), .inputSample(inputSample), .dftRead(dftRead),
    .fifoLevel(fifoLevel), .dropCount(dropCount)
`ifdef AUDIO_SEQ_PEAK_EN
    , .peakLevel(peak_level)
`endif
  );

  always #5 clk = ~clk;

  function automatic int to_int24(input logic [23:0] v);
    return v[23] ? int'(v) - (1 << 24) : int'(v);
  endfunction

  function automatic int model_sample(input logic [23:0] l, input logic [23:0] r);
    int s = to_int24(l) + to_int24(r);
    int t = s >= 0 ? s / 256 : -((-s + 255) / 256);
    return t > 32767 ? 32767 : t < -32768 ? -32768 : t;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ready"}, int'(sampleReady), q.size() > 0 ? 1 : 0);
    check({tag, "_head"}, int'(inputSample), q.size() > 0 ? q[0] : 0);
    check({tag, "_level"}, int'(fifoLevel), q.size());
    check({tag, "_drops"}, int'(dropCount), drops);
  endtask

  task automatic model_push(input logic [23:0] l, input logic [23:0] r, input int n);
    if (n < DEPTH) q.push_back(model_sample(l, r));
    else if (drops < 255) drops++;
  endtask

  task automatic episode(input logic [23:0] l, input logic [23:0] r, input int hold);
    int pulses = 0;
    int n = q.size();
    @(negedge clk);
    codecReadReady = 1'b1; codecLeft = l; codecRight = r;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (codecRead) pulses++;
    end
    codecReadReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (codecRead) pulses++;
    end
    check("ack_pulses", pulses, 1);
    model_push(l, r, n);
  endtask

  task automatic pop_pulse(input int hi, input int lo);
    @(negedge clk);
    dftRead = 1'b1;
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    dftRead = 1'b0;
    repeat (lo - 1) @(negedge clk);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic collide(input logic [23:0] l, input logic [23:0] r);
    int n = q.size();
    @(negedge clk);
    codecReadReady = 1'b1; codecLeft = l; codecRight = r;
    @(negedge clk);
    check("coll_ack", int'(codecRead), 1);
    dftRead = 1'b1;
    @(negedge clk);
    codecReadReady = 1'b0; dftRead = 1'b0;
    repeat (2) @(negedge clk);
    model_push(l, r, n);
    if (n > 0) void'(q.pop_front());
  endtask

  task automatic drain();
    while (q.size() > 0) pop_pulse(1, 1);
  endtask

  initial begin
    logic [23:0] l, r;
    rst_n = 1'b0; codecReadReady = 1'b0; dftRead = 1'b0; codecLeft = '0; codecRight = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", int'(codecRead), 0);
    check_state("reset");
    rst_n = 1'b1;
    episode(24'h000100, 24'h000200, 1);
    check("tp1_value", int'(inputSample), 3);
    check_state("tp1");
    drain();
    check_state("drain1");
    episode(24'h000400, 24'h000000, 20);
    check("hold20_level", int'(fifoLevel), 1);
    drain();
    episode(24'h7FFFFF, 24'h7FFFFF, 1);
    check("sat_pos", int'(inputSample), 32767);
    drain();
    episode(24'h800000, 24'h800000, 1);
    check("sat_neg", int'(inputSample), -32768);
    drain();
    episode(24'h7FFFFF, 24'h800000, 1);
    check("sat_mix", int'(inputSample), -1);
    drain();
    for (int i = 0; i < 7; i++) episode(24'(($urandom_range(1, 100)) << 8), 24'h000000, 2);
    check("fill_level", int'(fifoLevel), 4);
    check("fill_drops", int'(dropCount), 3);
    check_state("fill");
    collide(24'h000500, 24'h000000);
    check("coll_full_level", int'(fifoLevel), 3);
    check("coll_full_drops", int'(dropCount), 4);
    check_state("coll_full");
    drain();
    collide(24'h000700, 24'h000000);
    check("coll_empty_head", int'(inputSample), 7);
    check_state("coll_empty");
    for (int i = 0; i < 300; i++) episode(24'h001000, 24'h000000, 1);
    check("drop_sat", int'(dropCount), 255);
    check_state("drop_sat");
    drain();
    episode(24'h000100, 24'h000000, 1);
    episode(24'h000200, 24'h000000, 1);
    episode(24'h000300, 24'h000000, 1);
    pop_pulse(4, 2);
    pop_pulse(1, 2);
    check("pops_head", int'(inputSample), 3);
    check("pops_level", int'(fifoLevel), 1);
    check_state("pops");
    @(negedge clk);
    codecReadReady = 1'b1; codecLeft = 24'h001234; codecRight = 24'h000000;
    @(negedge clk);
    check("rst_mid_ack", int'(codecRead), 1);
    rst_n = 1'b0; codecReadReady = 1'b0;
    #1;
    check("rst_mid_drop", int'(codecRead), 0);
    q.delete();
    drops = 0;
    check_state("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_ack", int'(codecRead), 0);
    episode(24'h000900, 24'h000000, 1);
    check_state("rst_resume");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        l = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 24'h7FFFFF : 24'h800000) : 24'($urandom);
        r = 24'($urandom);
        episode(l, r, int'($urandom_range(1, 6)));
      end else begin
        pop_pulse(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)));
      end
      check_state("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
